// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_arb_pkg;
  localparam int REG_W   = 32;
  localparam int RADDR_W = 5;
  localparam int NREGS   = 32;

  typedef enum logic [0:0] {ARB_NORMAL = 1'b0, ARB_FORCE = 1'b1} arb_state_t;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [REG_W-1:0]   data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Pipeline-side bundle of the arbiter: WB request, multi-cycle result, issue/decode query, regfile port.
interface rf_wb_arbiter_if;
  import rf_arb_pkg::*;
  logic               wb_valid;
  logic [RADDR_W-1:0] wb_rd;
  logic [REG_W-1:0]   wb_data;
  logic               mc_valid;
  logic               mc_ready;
  logic [RADDR_W-1:0] mc_rd;
  logic [REG_W-1:0]   mc_data;
  logic               iss_valid;
  logic [RADDR_W-1:0] iss_rd;
  logic [RADDR_W-1:0] q_rs1;
  logic [RADDR_W-1:0] q_rs2;
  logic               hazard_o;
  logic [NREGS-1:0]   busy_o;
  logic               wb_stall_o;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_rd;
  logic [REG_W-1:0]   rf_wdata;

  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, iss_valid, iss_rd, q_rs1, q_rs2,
    input  mc_ready, hazard_o, busy_o, wb_stall_o, rf_we, rf_rd, rf_wdata
  );
  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, iss_valid, iss_rd, q_rs1, q_rs2,
    output mc_ready, hazard_o, busy_o, wb_stall_o, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/rf_arb_fifo.sv
// DEPTH-entry synchronous FIFO of pending multi-cycle writes; head is visible only after the write edge.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  rf_wr_t din,
  input  logic   pop,
  output rf_wr_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  rf_wr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB vs. multi-cycle results, pending-write scoreboard, anti-starvation FSM.
// Optional perf counters behind RF_ARB_PERF_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  rf_wb_arbiter_if.slave bus
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_o,
  output logic [31:0] perf_force_o
`endif
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  logic [CW-1:0]    starve_cnt;
  logic [NREGS-1:0] busy_q, busy_nxt;
  rf_wr_t           head, sel;
  logic             full, empty, push;
  logic             grant_wb, drain, direct, mc_wr, deny, force_enter;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({bus.mc_rd, bus.mc_data}),
    .pop   (drain),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    grant_wb = 1'b0;
    drain    = 1'b0;
    direct   = 1'b0;
    if (!reset) begin
      if (state == ARB_FORCE)                 drain    = !empty;
      else if (bus.wb_valid && bus.wb_rd != '0) grant_wb = 1'b1;
      else if (!empty)                        drain    = 1'b1;
      else if (bus.mc_valid && !full)         direct   = 1'b1;
    end
  end

  assign bus.mc_ready = !full && !reset;
  assign push  = bus.mc_valid && bus.mc_ready && !direct;
  assign mc_wr = drain || direct;

  always_comb begin
    sel = '0;
    if (grant_wb)    sel = {bus.wb_rd, bus.wb_data};
    else if (drain)  sel = head;
    else if (direct) sel = {bus.mc_rd, bus.mc_data};
  end

  // rd==0 results still occupy the port cycle but never reach the regfile
  assign bus.rf_we    = (grant_wb || mc_wr) && (sel.rd != '0);
  assign bus.rf_rd    = bus.rf_we ? sel.rd   : '0;
  assign bus.rf_wdata = bus.rf_we ? sel.data : '0;

  // Set is applied after clear so an op re-issued to the same rd stays pending
  always_comb begin
    busy_nxt = busy_q;
    if (mc_wr && sel.rd != '0) busy_nxt[sel.rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign bus.busy_o   = busy_q;
  assign bus.hazard_o = busy_q[bus.q_rs1] | busy_q[bus.q_rs2] | busy_q[bus.iss_rd];

  assign deny        = !empty && !drain;
  assign force_enter = (state == ARB_NORMAL) && deny && (starve_cnt == CW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
    end else if (state == ARB_FORCE || force_enter) begin
      state      <= (state == ARB_FORCE) ? ARB_NORMAL : ARB_FORCE;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= deny ? starve_cnt + 1'b1 : '0;
    end
  end

  assign bus.wb_stall_o = (state == ARB_FORCE);

  a_no_wb_in_force: assert property (@(posedge clk) disable iff (reset)
    (state == ARB_FORCE) |-> !bus.wb_valid);

`ifdef RF_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_o <= '0;
      perf_force_o    <= '0;
    end else begin
      if (bus.wb_valid && (!empty || bus.mc_valid) && perf_conflict_o != '1)
        perf_conflict_o <= perf_conflict_o + 1'b1;
      if (force_enter && perf_force_o != '1)
        perf_force_o <= perf_force_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: vector table for single-cycle behaviour, hand sequences for starvation/backpressure.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();
`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_force;
`endif

  rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RF_ARB_PERF_EN
    ,
    .perf_conflict_o (perf_conflict),
    .perf_force_o    (perf_force)
`endif
  );

  typedef struct {
    logic        wbv;  logic [4:0] wbrd; logic [31:0] wbd;
    logic        mcv;  logic [4:0] mcrd; logic [31:0] mcd;
    logic        issv; logic [4:0] issrd;
    logic [4:0]  rs1;  logic [4:0] rs2;
    logic        we;   logic [4:0] rd;   logic [31:0] wd;
    logic        rdy;  logic       haz;  logic [31:0] busy;
  } vec_t;

  vec_t v[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic mcv, input logic [4:0] mcrd, input logic [31:0] mcd,
                       input logic issv, input logic [4:0] issrd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.wb_valid = wbv;  bus.wb_rd = wbrd; bus.wb_data = wbd;
    bus.mc_valid = mcv;  bus.mc_rd = mcrd; bus.mc_data = mcd;
    bus.iss_valid = issv; bus.iss_rd = issrd;
    bus.q_rs1 = rs1; bus.q_rs2 = rs2;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] wd, input logic stall);
    chk({tag, " rf_we"},    32'(bus.rf_we), 32'(we));
    chk({tag, " rf_rd"},    32'(bus.rf_rd), 32'(rd));
    chk({tag, " rf_wdata"}, bus.rf_wdata, wd);
    chk({tag, " stall"},    32'(bus.wb_stall_o), 32'(stall));
  endtask

  initial begin
    //        wbv wbrd wbd      mcv mcrd mcd          iv ird rs1 rs2  we rd wd          rdy haz busy
    v[0]  = '{0, 0,  0,         0, 0,  0,            1, 5,  0,  0,   0, 0, 0,          1,  0,  0};
    v[1]  = '{0, 0,  0,         1, 5,  32'hDEAD,     0, 0,  5,  0,   1, 5, 32'hDEAD,   1,  1,  32'h20};
    v[2]  = '{0, 0,  0,         0, 0,  0,            0, 0,  5,  0,   0, 0, 0,          1,  0,  0};
    v[3]  = '{1, 3,  32'h11,    1, 7,  32'h22,       0, 0,  0,  0,   1, 3, 32'h11,     1,  0,  0};
    v[4]  = '{0, 0,  0,         0, 0,  0,            0, 0,  0,  0,   1, 7, 32'h22,     1,  0,  0};
    v[5]  = '{0, 0,  0,         0, 0,  0,            1, 9,  0,  0,   0, 0, 0,          1,  0,  0};
    v[6]  = '{0, 0,  0,         1, 9,  32'h99,       1, 9,  9,  0,   1, 9, 32'h99,     1,  1,  32'h200};
    v[7]  = '{0, 0,  0,         0, 0,  0,            0, 0,  9,  0,   0, 0, 0,          1,  1,  32'h200};
    v[8]  = '{0, 0,  0,         0, 0,  0,            0, 0,  0,  0,   0, 0, 0,          1,  0,  32'h200};
    v[9]  = '{0, 0,  0,         1, 9,  32'h77,       0, 0,  9,  0,   1, 9, 32'h77,     1,  1,  32'h200};
    v[10] = '{0, 0,  0,         0, 0,  0,            0, 0,  9,  0,   0, 0, 0,          1,  0,  0};
    v[11] = '{1, 0,  32'h55,    1, 4,  32'h44,       0, 0,  0,  0,   1, 4, 32'h44,     1,  0,  0};
    v[12] = '{1, 0,  32'h55,    0, 0,  0,            0, 0,  0,  0,   0, 0, 0,          1,  0,  0};
    v[13] = '{0, 0,  0,         1, 0,  32'h33,       0, 0,  0,  0,   0, 0, 0,          1,  0,  0};
    v[14] = '{1, 2,  32'h22,    1, 0,  32'h5,        0, 0,  0,  0,   1, 2, 32'h22,     1,  0,  0};
    v[15] = '{0, 0,  0,         0, 0,  0,            0, 0,  0,  0,   0, 0, 0,          1,  0,  0};
    v[16] = '{0, 0,  0,         0, 0,  0,            1, 12, 0,  0,   0, 0, 0,          1,  0,  0};
    v[17] = '{0, 0,  0,         0, 0,  0,            0, 0,  0,  12,  0, 0, 0,          1,  1,  32'h1000};
    v[18] = '{0, 0,  0,         0, 0,  0,            0, 12, 0,  0,   0, 0, 0,          1,  1,  32'h1000};
    v[19] = '{0, 0,  0,         1, 12, 32'hC,        0, 0,  0,  0,   1, 12, 32'hC,     1,  0,  32'h1000};
    v[20] = '{0, 0,  0,         0, 0,  0,            0, 0,  0,  0,   0, 0, 0,          1,  0,  0};

    // Reset with live requests on both sides: nothing may reach the port
    drive(1, 3, 32'h1, 1, 4, 32'h2, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d rf_we", c),    32'(bus.rf_we), 0);
      chk($sformatf("rst%0d mc_ready", c), 32'(bus.mc_ready), 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst busy", bus.busy_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post-rst mc_ready", 32'(bus.mc_ready), 1);
    chk("post-rst busy",     bus.busy_o, 0);
    chk_port("post-rst", 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      drive(v[i].wbv, v[i].wbrd, v[i].wbd, v[i].mcv, v[i].mcrd, v[i].mcd,
            v[i].issv, v[i].issrd, v[i].rs1, v[i].rs2);
      @(negedge clk);
      chk_port($sformatf("v%0d", i), v[i].we, v[i].rd, v[i].wd, 0);
      chk($sformatf("v%0d mc_ready", i), 32'(bus.mc_ready), 32'(v[i].rdy));
      chk($sformatf("v%0d hazard", i),   32'(bus.hazard_o), 32'(v[i].haz));
      chk($sformatf("v%0d busy", i),     bus.busy_o, v[i].busy);
    end

    // Starvation: one queued result, WB every cycle; forced drain in the 5th cycle after queueing
    @(posedge clk); #1;
    drive(1, 1, 32'h100, 1, 6, 32'h66, 0, 0, 0, 0);
    @(negedge clk);
    chk_port("st0", 1, 1, 32'h100, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      drive(k != 5, 5'(k + 1), 32'h100 + k, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k == 5) chk_port($sformatf("st%0d", k), 1, 6, 32'h66, 1);
      else        chk_port($sformatf("st%0d", k), 1, 5'(k + 1), 32'h100 + k, 0);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_port("st-idle", 0, 0, 0, 0);

    // Backpressure: DEPTH=2 fills, third result waits for the forced drain, order r11,r12,r13
    for (int c = 0; c < 10; c++) begin
      logic       wbv, mcv, e_rdy, e_we, e_stall;
      logic [4:0] mrd, e_rd;
      wbv = (c <= 6) && (c != 5);
      mcv = (c <= 6);
      mrd = (c == 0) ? 5'd11 : (c == 1) ? 5'd12 : 5'd13;
      e_rdy   = !(c >= 2 && c <= 5) && (c != 7);
      e_stall = (c == 5);
      e_we    = (c != 9);
      case (c)
        5:       e_rd = 5'd11;
        7:       e_rd = 5'd12;
        8:       e_rd = 5'd13;
        9:       e_rd = 5'd0;
        default: e_rd = 5'(20 + c);
      endcase
      @(posedge clk); #1;
      drive(wbv, 5'(20 + c), 32'h200 + c, mcv, mrd, 32'hB00 + 32'(mrd), 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("bp%0d mc_ready", c), 32'(bus.mc_ready), 32'(e_rdy));
      chk_port($sformatf("bp%0d", c), e_we, e_rd,
               !e_we ? 32'h0 : (e_rd >= 20) ? 32'h200 + c : 32'hB00 + 32'(e_rd), e_stall);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
